// File: rtl/axi_rd_arb_pkg.sv
// Shared widths, FSM state encoding and AR field bundle for the AXI read arbiter.
package axi_rd_arb_pkg;

   localparam int ADDR_W  = 32;
   localparam int ID_W    = 24;
   localparam int LEN_W   = 8;
   localparam int DATA_W  = 32;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int CNT_W   = LEN_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [ID_W-1:0]    id;
      logic [LEN_W-1:0]   len;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
   } ar_req_t;

   // Beats in a burst: arlen encodes length minus one, so widen before adding.
   function automatic logic [CNT_W-1:0] burst_beats(input logic [LEN_W-1:0] len);
      return {1'b0, len} + CNT_W'(1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, modulo N.
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] cand;
      // NOTE: every output gets a default before the search loop so no path
      // leaves a value unassigned and no latch is inferred.
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
         cand = sum[IDX_W-1:0];
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read master among NUM_REQ requesters,
// one outstanding burst at a time. Optional watchdog: define AXI_RD_ARB_TIMEOUT_EN.
module axi_rd_arbiter
   import axi_rd_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           s_arvalid,
   output logic [NUM_REQ-1:0]           s_arready,
   input  logic [NUM_REQ*ADDR_W-1:0]    s_araddr,
   input  logic [NUM_REQ*ID_W-1:0]      s_arid,
   input  logic [NUM_REQ*LEN_W-1:0]     s_arlen,
   input  logic [NUM_REQ*SIZE_W-1:0]    s_arsize,
   input  logic [NUM_REQ*BURST_W-1:0]   s_arburst,
   output logic [NUM_REQ-1:0]           s_rvalid,
   input  logic [NUM_REQ-1:0]           s_rready,
   output logic [DATA_W-1:0]            s_rdata,
   output logic [ID_W-1:0]              s_rid,
   output logic [1:0]                   s_rresp,
   output logic                         s_rlast,
   output logic                         m_arvalid,
   input  logic                         m_arready,
   output logic [ADDR_W-1:0]            m_araddr,
   output logic [ID_W-1:0]              m_arid,
   output logic [LEN_W-1:0]             m_arlen,
   output logic [SIZE_W-1:0]            m_arsize,
   output logic [BURST_W-1:0]           m_arburst,
   input  logic                         m_rvalid,
   output logic                         m_rready,
   input  logic [DATA_W-1:0]            m_rdata,
   input  logic [ID_W-1:0]              m_rid,
   input  logic [1:0]                   m_rresp,
   input  logic                         m_rlast,
   output logic [NUM_REQ-1:0]           grant_o,
   output logic                         err_len,
   output logic                         err_timeout
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("axi_rd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   state_t             state, state_n;
   logic [IDX_W-1:0]   ptr, gnt_idx, pick_idx;
   logic [NUM_REQ-1:0] gnt_q, pick_gnt;
   logic               pick_valid;
   ar_req_t            ar_q;
   logic [CNT_W-1:0]   beat_cnt, beat_next, exp_beats;
   logic               ar_hs, r_hs, len_bad, timeout;

   rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
      .req   (s_arvalid),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign ar_hs     = (state == ADDR) && m_arready;
   assign r_hs      = (state == DATA) && m_rvalid && m_rready;
   assign beat_next = beat_cnt + CNT_W'(1);
   assign exp_beats = burst_beats(ar_q.len);
   // A short burst is only known at rlast; an over-long one is flagged on the first extra beat.
   assign len_bad   = m_rlast ? (beat_next != exp_beats) : (beat_next > exp_beats);

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (pick_valid) state_n = ADDR;
         ADDR:    if (timeout) state_n = IDLE;
                  else if (ar_hs) state_n = DATA;
         DATA:    if (timeout || (r_hs && m_rlast)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= '0;
         gnt_idx  <= '0;
         gnt_q    <= '0;
         ar_q     <= '0;
         beat_cnt <= '0;
         err_len  <= 1'b0;
      end else begin
         state <= state_n;
         if (state == IDLE && pick_valid) begin
            gnt_idx <= pick_idx;
            gnt_q   <= pick_gnt;
            ar_q    <= '{addr:  s_araddr [pick_idx*ADDR_W  +: ADDR_W],
                         id:    s_arid   [pick_idx*ID_W    +: ID_W],
                         len:   s_arlen  [pick_idx*LEN_W   +: LEN_W],
                         size:  s_arsize [pick_idx*SIZE_W  +: SIZE_W],
                         burst: s_arburst[pick_idx*BURST_W +: BURST_W]};
         end
         if (ar_hs) beat_cnt <= '0;
         else if (r_hs) beat_cnt <= beat_next;
         if (r_hs && len_bad) err_len <= 1'b1;
         if ((r_hs && m_rlast) || timeout)
            ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

`ifdef AXI_RD_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            err_to_q;

   // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an AR or R handshake.
   assign timeout = (state != IDLE) && !(ar_hs || r_hs) &&
                    (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt   <= '0;
         err_to_q <= 1'b0;
      end else begin
         if (state == IDLE || ar_hs || r_hs || timeout) wd_cnt <= '0;
         else wd_cnt <= wd_cnt + WD_W'(1);
         if (timeout) err_to_q <= 1'b1;
      end
   end

   assign err_timeout = err_to_q;
`else
   assign timeout     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   assign grant_o   = (state != IDLE) ? gnt_q : '0;
   assign s_arready = ar_hs ? gnt_q : '0;
   assign s_rvalid  = (state == DATA && m_rvalid) ? gnt_q : '0;
   assign m_rready  = (state == DATA) && |(s_rready & gnt_q);

   assign m_arvalid = (state == ADDR);
   assign m_araddr  = ar_q.addr;
   assign m_arid    = ar_q.id;
   assign m_arlen   = ar_q.len;
   assign m_arsize  = ar_q.size;
   assign m_arburst = ar_q.burst;

   assign s_rdata = (state == DATA) ? m_rdata : '0;
   assign s_rid   = (state == DATA) ? m_rid   : '0;
   assign s_rresp = (state == DATA) ? m_rresp : '0;
   assign s_rlast = (state == DATA) && m_rlast;

endmodule
